act_skew_feeder: RTL and testbench
==================================

Name: act_skew_feeder

Overview:
- Upstream feeder for the weight-stationary PE array.
- Accepts one activation vector per handshake, ROWS lanes of 16-bit Q5.10 each, and drives each array row's A_in input with a per-row diagonal skew: row r is delayed r cycles relative to row 0.
- Frames a tile of tile_len vectors, drains the skew pipeline, then pulses done.
- Lanes carry exact zero whenever no valid data is present. The PEs accumulate every cycle, so a zero A contributes nothing.

Parameters:
- ROWS, 4, number of array rows / activation lanes (>=1)
- DATA_W, 16, activation width per lane (Q5.10)
- LEN_W, 8, width of the tile-length field

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle tile start request
- tile_len  in  LEN_W  vectors in tile (K); sampled with start
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse; last vector present on lane ROWS-1
- in_valid  in  1  upstream vector valid
- in_ready  out  1  feeder accepts vector this cycle
- in_data  in  ROWS*DATA_W  lane r = bits [r*DATA_W +: DATA_W]
- a_out  out  ROWS*DATA_W  skewed activations to array rows (lane r -> row r A_in)
- a_valid  out  ROWS  per-lane valid marker

Behaviour:
- Reset (async, any state): state=IDLE; a_out=0; a_valid=0; in_ready=0; busy=0; done=0; all skew registers, beat counter and flush counter cleared. Beats in flight are discarded.
- FSM states: IDLE, STREAM, FLUSH.
- IDLE:
  - in_ready=0.
  - start=1 with tile_len!=0: latch K=tile_len, clear beat count, go to STREAM.
  - start with tile_len==0: ignored; stay IDLE, no done.
- STREAM:
  - in_ready=1 (combinational on state).
  - A beat is accepted when in_valid&&in_ready; beat count increments.
  - When the K-th beat is accepted: go to FLUSH, or go directly to IDLE with done when ROWS==1.
  - Cycles with in_valid=0 insert a bubble: zero data, valid 0.
  - The pipeline never stalls; downstream has no backpressure.
- FLUSH:
  - in_ready=0; flush counter runs ROWS-1 cycles.
  - At the end: state=IDLE, done=1 for exactly one cycle.
- start while busy: ignored, with no effect on the latched K.
- Skew pipeline, all registered:
  - Lane 0: 1-cycle register.
  - Lane r: r+1 register stages total.
  - A beat accepted at edge E appears on lane r (a_out and a_valid[r]=1) in the cycle following edge E+r.
  - Stage 0 loads in_data with valid=1 when a beat is accepted, else zeros with valid=0.
- Zero forcing: a_out lane r = 0 whenever a_valid[r]=0.
- done timing: asserted in the same cycle lane ROWS-1 presents the K-th beat. done and busy fall on the following cycle; busy is already 0 in the done cycle, since state=IDLE.
- Back-to-back tiles: start may be asserted in the done cycle. The new tile's first beat cannot be accepted before the cycle after start.
- Pass-through only: no arithmetic is performed on data; width is preserved per lane.

Test Plan:
- Reset: assert rst_n=0 mid-STREAM with beats in flight -> all outputs 0 immediately (async); after release, state IDLE and in_ready=0.
- Basic skew (ROWS=4, K=3):
  - Stimulus: start, tile_len=3, then in_valid continuously, vectors {lane0..3} = {0x0400,0x0800,0x0C00,0x1000} (×beat index 1,2,3).
  - Lane0 shows beats 1,2,3 in cycles c+1..c+3; lane3 shows them in c+4..c+6.
  - done pulses in the cycle lane3 shows beat 3.
  - All other lane cycles read 0 with a_valid=0.
- Bubbles:
  - Stimulus: K=2, in_valid high, low, high.
  - Each lane shows beat1, a zero/valid-0 cycle, then beat2.
  - done is delayed by exactly 1 cycle versus the contiguous case.
- tile_len=0 and start-while-busy:
  - start with tile_len=0 -> busy stays 0, no done.
  - start pulse during STREAM with tile_len=5 -> ignored; the original K=2 tile completes with a single done.
- Back-to-back: start asserted in the done cycle with K=1 -> second tile accepted; its lane3 output follows the same r-cycle skew; two done pulses total.
- Negative values: lane value 0xFC00 (-1.0 Q5.10) -> emerges bit-exact on every lane after its skew.

Source files
------------

// File: rtl/act_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : act_skew_feeder_if
// Description : Upstream activation-vector handshake (valid/ready + lanes).
// Revision    : 1.0 - initial release
// ============================================================================
interface act_skew_feeder_if #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   in_data;

    // Producer side (vector source).
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Consumer side (the skew feeder).
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/act_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : act_skew_feeder
// Description : Frames a tile of activation vectors and feeds them to the PE
//               array with a diagonal skew (row r delayed r cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module act_skew_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   start,
    input  wire logic [LEN_W-1:0]       tile_len,
    output logic                        busy,
    output logic                        done,
    act_skew_feeder_if.slave            in_bus,
    output logic [ROWS*DATA_W-1:0]      a_out,
    output logic [ROWS-1:0]             a_valid
);

    localparam int FC_W = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'((ROWS > 1) ? (ROWS - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [FC_W-1:0]    flush_q, flush_d;
    logic               done_q, done_d;
    logic               accept;

    assign in_bus.in_ready = (state_q == S_STREAM);
    assign accept          = in_bus.in_valid && (state_q == S_STREAM);
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (tile_len != '0)) begin
                    k_d     = tile_len;
                    beat_d  = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q == (k_q - LEN_W'(1))) begin
                        // A single row has no skew to drain.
                        if (ROWS == 1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_FLUSH;
                            flush_d = '0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + FC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    // Lane r owns a private r+1 stage shift register for its slice only.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_W-1:0] dat_q [0:r];
        logic [DATA_W-1:0] dat_d [0:r];
        logic [r:0]        vld_q;
        logic [r:0]        vld_d;

        always_comb begin
            dat_d[0] = accept ? in_bus.in_data[r*DATA_W +: DATA_W] : '0;
            vld_d    = '0;
            vld_d[0] = accept;
            for (int s = 1; s <= r; s++) begin
                dat_d[s] = dat_q[s-1];
                vld_d[s] = vld_q[s-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    dat_q[s] <= '0;
                end
                vld_q <= '0;
            end else begin
                for (int s = 0; s <= r; s++) begin
                    dat_q[s] <= dat_d[s];
                end
                vld_q <= vld_d;
            end
        end

        assign a_out[r*DATA_W +: DATA_W] = vld_q[r] ? dat_q[r] : '0;
        assign a_valid[r]                = vld_q[r];
    end

endmodule
`default_nettype wire

// File: tb/tb_act_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_skew_feeder
// Description : Self-checking bench for act_skew_feeder against a beat-history model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_skew_feeder;

    localparam int ROWS   = 4;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;
    localparam int HIST   = 8192;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        tile_len = '0;
    logic                    busy;
    logic                    done;
    logic [ROWS*DATA_W-1:0]  a_out;
    logic [ROWS-1:0]         a_valid;

    act_skew_feeder_if #(.ROWS(ROWS), .DATA_W(DATA_W)) u_if ();

    act_skew_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tile_len (tile_len),
        .busy     (busy),
        .done     (done),
        .in_bus   (u_if.slave),
        .a_out    (a_out),
        .a_valid  (a_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a tile is K accepted beats; beat accepted at edge E is
    // seen on lane r after edge E+r; done follows the last beat by ROWS-1 edges.
    int                      n = 0;
    int                      m_floor = 0;
    int                      m_done_edge = -1;
    int                      m_end_edge = -1;
    int                      m_left = 0;
    bit                      m_stream = 1'b0;
    bit                      m_busy = 1'b0;
    bit                      acc_v [0:HIST-1];
    logic [ROWS*DATA_W-1:0]  acc_d [0:HIST-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stream    = 1'b0;
            m_busy      = 1'b0;
            m_left      = 0;
            m_done_edge = -1;
            m_end_edge  = -1;
            m_floor     = n;
        end else begin
            n = n + 1;
            acc_v[n] = 1'b0;
            acc_d[n] = '0;
            if (m_stream && u_if.in_valid) begin
                acc_v[n] = 1'b1;
                acc_d[n] = u_if.in_data;
                m_left   = m_left - 1;
                if (m_left == 0) begin
                    m_stream   = 1'b0;
                    m_end_edge = n + ROWS - 1;
                end
            end else if (!m_busy && start && (tile_len != 0)) begin
                m_stream = 1'b1;
                m_busy   = 1'b1;
                m_left   = int'(tile_len);
            end
            if (m_busy && !m_stream && (n == m_end_edge)) begin
                m_busy      = 1'b0;
                m_done_edge = n;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {63'd0, u_if.in_ready}, {63'd0, m_stream});
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        chk("done", {63'd0, done}, {63'd0, (n == m_done_edge)});
        for (int r = 0; r < ROWS; r++) begin
            int              idx;
            bit              ev;
            logic [DATA_W-1:0] ed;
            idx = n - r;
            ev  = (idx > m_floor) ? acc_v[idx] : 1'b0;
            ed  = ev ? acc_d[idx][r*DATA_W +: DATA_W] : '0;
            chk($sformatf("lane%0d_valid", r), {63'd0, a_valid[r]}, {63'd0, ev});
            chk($sformatf("lane%0d_data", r), {48'd0, a_out[r*DATA_W +: DATA_W]}, {48'd0, ed});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int len);
        start    = 1'b1;
        tile_len = LEN_W'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic beat(input logic [ROWS*DATA_W-1:0] d, input bit v);
        u_if.in_valid = v;
        u_if.in_data  = d;
        tick();
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
    endtask

    function automatic logic [ROWS*DATA_W-1:0] ramp(input int b);
        logic [ROWS*DATA_W-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'(16'h0400 * (r + 1) * b);
        return v;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 60) begin
            tick();
            k++;
        end
        chk("idle_timeout", {63'd0, (k >= 60)}, 64'd0);
        tick();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        chk("done_timeout", {63'd0, (k >= 60)}, 64'd0);
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Contiguous tile, K=3.
        pulse_start(3);
        for (int b = 1; b <= 3; b++) beat(ramp(b), 1'b1);
        wait_idle();

        // Bubble in the middle, K=2.
        pulse_start(2);
        beat(ramp(1), 1'b1);
        beat('0, 1'b0);
        beat(ramp(2), 1'b1);
        wait_idle();

        // Zero-length start is ignored.
        pulse_start(0);
        repeat (4) tick();

        // Start during STREAM must not disturb the latched K.
        pulse_start(2);
        beat(ramp(3), 1'b1);
        start = 1'b1;
        tile_len = 8'd5;
        beat(ramp(4), 1'b1);
        start = 1'b0;
        repeat (3) beat(ramp(5), 1'b1);
        wait_idle();

        // Back-to-back K=1 tiles, second start in the done cycle.
        pulse_start(1);
        beat(ramp(6), 1'b1);
        wait_done();
        pulse_start(1);
        beat(ramp(7), 1'b1);
        wait_idle();

        // Negative value passes through bit-exact.
        pulse_start(2);
        beat({ROWS{16'hFC00}}, 1'b1);
        beat({ROWS{16'hFC00}}, 1'b1);
        wait_idle();

        // Asynchronous reset with beats in flight.
        pulse_start(5);
        beat(ramp(2), 1'b1);
        beat(ramp(3), 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_a_out", a_out, 64'd0);
        chk("rst_a_valid", {60'd0, a_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_in_ready", {63'd0, u_if.in_ready}, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            start         = ($urandom_range(0, 7) == 0);
            tile_len      = LEN_W'($urandom_range(0, 6));
            u_if.in_valid = ($urandom_range(0, 3) != 0);
            u_if.in_data  = {$urandom, $urandom};
            tick();
        end
        start = 1'b0;
        u_if.in_valid = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
